// File: rtl/jtag_tap_controller_if.sv
// JTAG pin bundle between the board-side probe and the TAP controller.
// master drives TMS/TDI; slave (the TAP) drives TDO and its enable.
interface jtag_tap_controller_if;
    logic jtagTms;
    logic jtagSerialIn;
    logic jtagSerialOut;
    logic jtagSerialOutEn;

    modport master (
        output jtagTms,
        output jtagSerialIn,
        input  jtagSerialOut,
        input  jtagSerialOutEn
    );

    modport slave (
        input  jtagTms,
        input  jtagSerialIn,
        output jtagSerialOut,
        output jtagSerialOutEn
    );
endinterface

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, IR, BYPASS and USER data registers.
// Define JTAG_IDCODE_EN to add the 32-bit IDCODE register and make it the reset instruction.
module jtag_tap_controller #(
    parameter int          IR_WIDTH     = 4,
    parameter int          DR_WIDTH     = 8,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
    parameter int          IDCODE_OPC   = 1,
    parameter int          USER_OPC     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    jtag_tap_controller_if.slave jtag,
    output logic [3:0]           tapState,
    output logic [IR_WIDTH-1:0]  irValue,
    input  logic [DR_WIDTH-1:0]  userDrIn,
    output logic [DR_WIDTH-1:0]  userDrOut,
    output logic                 userUpdatePulse
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tapState_t;

    localparam logic [IR_WIDTH-1:0] USER_CODE   = IR_WIDTH'(USER_OPC);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(2'b01);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IDCODE_CODE = IR_WIDTH'(IDCODE_OPC);
    localparam logic [IR_WIDTH-1:0] IR_RESET    = IDCODE_CODE;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET    = '1;
`endif

    if (IR_WIDTH < 2 || DR_WIDTH < 1 || IDCODE_VALUE[0] != 1'b1 ||
        IDCODE_OPC < 0 || IDCODE_OPC >= (1 << IR_WIDTH)) begin : gBadParams
        $error("jtag_tap_controller: illegal parameter combination");
    end

    tapState_t state, nextState;

    logic [IR_WIDTH-1:0] irShift;
    logic [DR_WIDTH-1:0] userShift;
    logic                bypassReg;
    logic                selUser;
    logic                tdo;
`ifdef JTAG_IDCODE_EN
    logic [31:0]         idcodeShift;
    logic                selIdcode;
`endif

    wire tms = jtag.jtagTms;
    wire tdi = jtag.jtagSerialIn;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= TLR;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            TLR:    nextState = tms ? TLR    : RTI;
            RTI:    nextState = tms ? SEL_DR : RTI;
            SEL_DR: nextState = tms ? SEL_IR : CAP_DR;
            CAP_DR: nextState = tms ? EX1_DR : SH_DR;
            SH_DR:  nextState = tms ? EX1_DR : SH_DR;
            EX1_DR: nextState = tms ? UPD_DR : PAU_DR;
            PAU_DR: nextState = tms ? EX2_DR : PAU_DR;
            EX2_DR: nextState = tms ? UPD_DR : SH_DR;
            UPD_DR: nextState = tms ? SEL_DR : RTI;
            SEL_IR: nextState = tms ? TLR    : CAP_IR;
            CAP_IR: nextState = tms ? EX1_IR : SH_IR;
            SH_IR:  nextState = tms ? EX1_IR : SH_IR;
            EX1_IR: nextState = tms ? UPD_IR : PAU_IR;
            PAU_IR: nextState = tms ? EX2_IR : PAU_IR;
            EX2_IR: nextState = tms ? UPD_IR : SH_IR;
            UPD_IR: nextState = tms ? SEL_DR : RTI;
            default: nextState = TLR;
        endcase
    end

    // DR selection follows the committed instruction, which only moves in UPD_IR or TLR.
    assign selUser = (irValue == USER_CODE);
`ifdef JTAG_IDCODE_EN
    assign selIdcode = !selUser && (irValue == IDCODE_CODE);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irShift <= '0;
            irValue <= IR_RESET;
        end else begin
            if (state == CAP_IR)     irShift <= IR_CAPTURE;
            else if (state == SH_IR) irShift <= {tdi, irShift[IR_WIDTH-1:1]};

            if (nextState == TLR)     irValue <= IR_RESET;
            else if (state == UPD_IR) irValue <= irShift;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bypassReg       <= 1'b0;
            userShift       <= '0;
            userDrOut       <= '0;
            userUpdatePulse <= 1'b0;
        end else begin
            userUpdatePulse <= 1'b0;
            if (state == CAP_DR) begin
                bypassReg <= 1'b0;
                if (selUser) userShift <= userDrIn;
            end else if (state == SH_DR) begin
                bypassReg <= tdi;
                // Shift expressed without slicing so DR_WIDTH=1 stays legal.
                if (selUser) userShift <= (userShift >> 1) | (DR_WIDTH'(tdi) << (DR_WIDTH - 1));
            end else if (state == UPD_DR && selUser) begin
                userDrOut       <= userShift;
                userUpdatePulse <= 1'b1;
            end
        end
    end

`ifdef JTAG_IDCODE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idcodeShift <= '0;
        end else if (selIdcode) begin
            if (state == CAP_DR)     idcodeShift <= IDCODE_VALUE;
            else if (state == SH_DR) idcodeShift <= {tdi, idcodeShift[31:1]};
        end
    end
`endif

    always_comb begin
        tdo = 1'b0;
        if (state == SH_IR) begin
            tdo = irShift[0];
        end else if (state == SH_DR) begin
            if (selUser) tdo = userShift[0];
`ifdef JTAG_IDCODE_EN
            else if (selIdcode) tdo = idcodeShift[0];
`endif
            else tdo = bypassReg;
        end
    end

    assign jtag.jtagSerialOut   = tdo;
    assign jtag.jtagSerialOutEn = (state == SH_DR) || (state == SH_IR);
    assign tapState             = state;

endmodule
